// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles serial bytes into 24-bit instruction words and writes them to instruction memory
//   CLK        : rising-edge clock
//   reset      : synchronous active-low reset
//   start      : begin a load (honoured in IDLE and DONE only)
//   byte_in    : serial instruction byte, MSB-first within each word
//   byte_valid : byte_in valid; accepted when byte_ready is also 1
//   byte_ready : loader can take a byte (LOAD state only)
//   wr_en      : one-cycle memory write strobe
//   wr_addr    : memory word address
//   wr_data    : assembled instruction word
//   cpu_reset  : holds the core in reset until the load is done
//   busy       : load in progress
//   done       : load completed (level)
//   full_err   : memory filled without seeing HALT_WORD
//   word_count : words written in the current or last load
module instr_mem_loader #(
    parameter logic [23:0] HALT_WORD = 24'h700007,
    parameter int          DEPTH     = 256
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        full_err,
    output logic [8:0]  word_count
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    localparam logic [7:0] LAST = 8'(DEPTH - 1);
    state_t      state;
    logic [1:0]  byte_idx;
    logic [15:0] acc;
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            acc        <= 16'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 24'd0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            full_err   <= 1'b0;
            word_count <= 9'd0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= LOAD;
                    wr_addr    <= 8'd0;
                    word_count <= 9'd0;
                    byte_idx   <= 2'd0;
                    full_err   <= 1'b0;
                    done       <= 1'b0;
                    byte_ready <= 1'b1;
                    busy       <= 1'b1;
                    cpu_reset  <= 1'b1;
                end
                LOAD: if (byte_valid) begin
                    acc      <= {acc[7:0], byte_in};
                    byte_idx <= byte_idx + 2'd1;
                    // third byte completes the word; the two earlier bytes sit in acc
                    if (byte_idx == 2'd2) begin
                        state      <= WRITE;
                        wr_data    <= {acc, byte_in};
                        wr_en      <= 1'b1;
                        byte_ready <= 1'b0;
                        byte_idx   <= 2'd0;
                    end
                end
                WRITE: begin
                    word_count <= word_count + 9'd1;
                    // HALT wins over a full memory when both happen on the same write
                    if (wr_data == HALT_WORD || wr_addr == LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b0;
                        full_err  <= (wr_data != HALT_WORD);
                    end else begin
                        state      <= LOAD;
                        wr_addr    <= wr_addr + 8'd1;
                        byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wr_en, cpu_reset, busy, done, full_err;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic [8:0]  word_count;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] wq[$];

    instr_mem_loader dut (
        .CLK(CLK), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .full_err(full_err), .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    // log every write as {addr, data} using the values held during the cycle
    always @(posedge CLK) if (wr_en) wq.push_back({wr_addr, wr_data});

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 20) begin
            tick;
            t++;
        end
        if (t >= 20) chk("accept_timeout", 32'(t), 32'd0);
        tick;
        byte_valid = 1'b0;
    endtask

    task automatic word(input logic [23:0] w);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
        tick;
    endtask

    task automatic go;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        // reset state
        tick;
        tick;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full_err", 32'(full_err), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b1;
        tick;
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // basic load with backpressure during WRITE
        go;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(byte_ready), 32'd1);
        chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        chk("w0_wr_en", 32'(wr_en), 32'd1);
        chk("w0_data", 32'(wr_data), 32'h123456);
        chk("w0_addr", 32'(wr_addr), 32'd0);
        chk("w0_ready", 32'(byte_ready), 32'd0);
        byte_in = 8'h70;
        byte_valid = 1'b1;
        tick;
        chk("bp_ready", 32'(byte_ready), 32'd1);
        chk("bp_wr_en", 32'(wr_en), 32'd0);
        chk("bp_count", 32'(word_count), 32'd1);
        chk("bp_addr", 32'(wr_addr), 32'd1);
        tick;
        byte_valid = 1'b0;
        chk("bp_after_wr_en", 32'(wr_en), 32'd0);
        send(8'h00);
        send(8'h07);
        chk("w1_wr_en", 32'(wr_en), 32'd1);
        chk("w1_data", 32'(wr_data), 32'h700007);
        chk("w1_addr", 32'(wr_addr), 32'd1);
        tick;
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        chk("basic_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("basic_count", 32'(word_count), 32'd2);
        chk("basic_full_err", 32'(full_err), 32'd0);
        chk("basic_ready", 32'(byte_ready), 32'd0);
        chk("basic_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("basic_log0", wq[0], {8'd0, 24'h123456});
            chk("basic_log1", wq[1], {8'd1, 24'h700007});
        end

        // restart from DONE, start while busy, then mid-word reset
        wq.delete();
        go;
        chk("rs_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_count", 32'(word_count), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        word(24'hABCDEF);
        send(8'h11);
        go;
        chk("sb_addr", 32'(wr_addr), 32'd1);
        chk("sb_count", 32'(word_count), 32'd1);
        send(8'h22);
        send(8'h33);
        tick;
        chk("sb_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("rs_log0", wq[0], {8'd0, 24'hABCDEF});
            chk("sb_log1", wq[1], {8'd1, 24'h112233});
        end
        send(8'h44);
        send(8'h55);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ready", 32'(byte_ready), 32'd0);
        chk("mr_wr_en", 32'(wr_en), 32'd0);
        chk("mr_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mr_count", 32'(word_count), 32'd0);
        chk("mr_addr", 32'(wr_addr), 32'd0);
        tick;
        chk("mr_wr_en2", 32'(wr_en), 32'd0);
        chk("mr_nwrites", 32'(wq.size()), 32'd2);
        wq.delete();
        go;
        send(8'h70);
        send(8'h00);
        send(8'h07);
        chk("mr_new_wr_en", 32'(wr_en), 32'd1);
        chk("mr_new_data", 32'(wr_data), 32'h700007);
        chk("mr_new_addr", 32'(wr_addr), 32'd0);
        tick;
        chk("mr_new_done", 32'(done), 32'd1);
        chk("mr_new_count", 32'(word_count), 32'd1);

        // fill all 256 words without HALT
        wq.delete();
        go;
        for (int i = 0; i < 256; i++) word({8'h01, 8'(i), 8'h5A});
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(full_err), 32'd1);
        chk("full_count", 32'(word_count), 32'd256);
        chk("full_addr", 32'(wr_addr), 32'd255);
        chk("full_busy", 32'(busy), 32'd0);
        tick;
        tick;
        chk("full_nwrites", 32'(wq.size()), 32'd256);
        for (int i = 0; i < wq.size() && i < 256; i++) chk("full_log", wq[i], {8'(i), 8'h01, 8'(i), 8'h5A});

        // HALT landing on the last address counts as a HALT termination
        wq.delete();
        go;
        for (int i = 0; i < 255; i++) word({8'h02, 8'(i), 8'hA5});
        word(24'h700007);
        chk("hl_done", 32'(done), 32'd1);
        chk("hl_full_err", 32'(full_err), 32'd0);
        chk("hl_count", 32'(word_count), 32'd256);
        chk("hl_nwrites", 32'(wq.size()), 32'd256);
        if (wq.size() == 256) chk("hl_last", wq[255], {8'd255, 24'h700007});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter HALT_WORD, default 24'h700007, meaning the terminating instruction that ends a load.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the instruction memory depth in 24-bit words.
REQ-003 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a load.
REQ-006 The block SHALL have port byte_in, input, 8 bits: serial instruction byte.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the loader accepts byte_in this cycle.
REQ-009 The block SHALL have port wr_en, output, 1 bit: instruction memory write strobe.
REQ-010 The block SHALL have port wr_addr, output, 8 bits: instruction memory word address.
REQ-011 The block SHALL have port wr_data, output, 24 bits: instruction word to write.
REQ-012 The block SHALL have port cpu_reset, output, 1 bit, active-high: holds the PC/instruction-memory core in reset.
REQ-013 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: the load has completed; level signal.
REQ-015 The block SHALL have port full_err, output, 1 bit: memory filled without HALT_WORD.
REQ-016 The block SHALL have port word_count, output, 9 bits: number of words written in the current or last load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-018 In IDLE, start=1 SHALL transition to LOAD and clear wr_addr, word_count, the byte index, full_err and done.
REQ-019 A byte SHALL be accepted on a rising edge where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in LOAD.
REQ-020 Bytes SHALL be assembled MSB first: first byte to bits [23:16], second to [15:8], third to [7:0].
REQ-021 Acceptance of the third byte SHALL move the FSM to WRITE and present the assembled word on wr_data.
REQ-022 In WRITE, wr_en SHALL be 1 for exactly one cycle with stable wr_addr and wr_data; byte_ready SHALL be 0.
REQ-023 On leaving WRITE, word_count SHALL increment by 1.
REQ-024 If the written word equals HALT_WORD, the next state SHALL be DONE; HALT_WORD is itself written to memory.
REQ-025 Else, if wr_addr == DEPTH-1, the next state SHALL be DONE with full_err=1; wr_addr SHALL NOT wrap.
REQ-026 Else, wr_addr SHALL increment by 1 and the next state SHALL be LOAD.
REQ-027 If both HALT_WORD and the last address occur in the same write, the load SHALL count as a HALT termination with full_err=0.
REQ-028 start SHALL be ignored in LOAD and WRITE.
REQ-029 A byte_valid pulse with byte_ready=0 SHALL be dropped and not accepted.
REQ-030 In DONE, done SHALL be 1 and cpu_reset SHALL be 0; start=1 SHALL restart as in REQ-018.
REQ-031 cpu_reset SHALL be 1 in IDLE, LOAD and WRITE.
REQ-032 busy SHALL be 1 in LOAD and WRITE only.
REQ-033 The latency from acceptance of the third byte to wr_en=1 SHALL be exactly 1 cycle.

Reset
REQ-034 When reset=0 at a rising edge, the FSM SHALL go to IDLE with wr_en=0, wr_addr=0, wr_data=0, byte_ready=0, busy=0, done=0, full_err=0, word_count=0 and cpu_reset=1.
REQ-035 Reset in any state, including mid-word in LOAD or in WRITE, SHALL discard partial bytes and suppress wr_en on the following cycle.
REQ-036 reset SHALL take priority over start and byte_valid.

Verification
REQ-037 The bench SHALL cover basic load: reset, start, then bytes 12 34 56 70 00 07 -> writes of 24'h123456 at addr 0 and 24'h700007 at addr 1; then done=1, word_count=2, cpu_reset=0.
REQ-038 The bench SHALL cover backpressure: byte_valid held high during WRITE -> no byte accepted that cycle; the byte is accepted on the next LOAD cycle and is not duplicated.
REQ-039 The bench SHALL cover full: 256 non-HALT words -> last write at addr 255, then DONE with full_err=1, word_count=256, and no write to addr 0.
REQ-040 The bench SHALL cover mid-word reset: after 2 bytes, reset=0 for one cycle -> IDLE, no wr_en; a new load starts from addr 0 with a fresh byte index.
REQ-041 The bench SHALL cover a start while busy: start pulsed during LOAD -> no effect on wr_addr or word_count.
REQ-042 The bench SHALL cover a restart: start in DONE -> cpu_reset=1, done=0, word_count=0, and the next write goes to addr 0.
